// File: rtl/operand_sequencer.sv
// operand_sequencer: control FSM for the 4-bit calculator datapath.
// Converts keyboard strobes into load/clear pulses for accumulators A and B,
// holds the ALU op select, waits EXEC_CYCLES for the ALU to settle and then
// pulses the result-register latch. All outputs are registered.
// Optional feature macro: OPERAND_CHAIN_EN (an op key in SHOW chains the
// result into A and starts a new operation instead of flagging an error).
module operand_sequencer #(
  parameter int EXEC_CYCLES = 2,   // ALU settle cycles, legal 1..15
  parameter int TIMEOUT_CYC = 255  // idle cycles allowed in WAIT_B, 0 = never
) (
  input  logic       MainClock,
  input  logic       ResetN,
  input  logic       KeyValid,
  input  logic       KeyIsOp,
  input  logic [3:0] KeyCode,
  output logic       KeyAck,
  output logic       LatchA,
  output logic       LatchB,
  output logic       ClearA,
  output logic       ClearB,
  output logic [1:0] AluOp,
  output logic       LatchOut,
  output logic       SelResult,
  output logic       Busy,
  output logic       Error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GOT_A  = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } state_t;

  // The first EXEC cycle lets B load; the settle count then runs to ELAST.
  localparam logic [3:0]  ELAST      = 4'(EXEC_CYCLES);
  localparam logic [15:0] TLIM       = 16'(TIMEOUT_CYC - 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);

  state_t      state_r, state_nx;
  logic [3:0]  ecnt_r, ecnt_nx;
  logic [15:0] tcnt_r, tcnt_nx;
  logic        ack_r, ack_nx;
  logic        lata_r, lata_nx;
  logic        latb_r, latb_nx;
  logic        clra_r, clra_nx;
  logic        clrb_r, clrb_nx;
  logic [1:0]  op_r, op_nx;
  logic        lout_r, lout_nx;
  logic        busy_r, busy_nx;
  logic        err_r, err_nx;
`ifdef OPERAND_CHAIN_EN
  logic        sel_r, sel_nx;
`endif

  logic key_take_s;
  logic is_clear_s;
  logic is_bad_op_s;

  // Key acceptance and key classification.
  always_comb begin
    key_take_s  = KeyValid && !ack_r && (state_r != ST_EXEC);
    is_clear_s  = KeyIsOp && (KeyCode == 4'hF);
    is_bad_op_s = KeyIsOp && (KeyCode >= 4'h4) && (KeyCode <= 4'hE);
  end

  // Next-state and next-output logic; every pulse defaults low.
  always_comb begin
    state_nx = state_r;
    ecnt_nx  = ecnt_r;
    tcnt_nx  = tcnt_r;
    op_nx    = op_r;
    ack_nx   = 1'b0;
    lata_nx  = 1'b0;
    latb_nx  = 1'b0;
    clra_nx  = 1'b0;
    clrb_nx  = 1'b0;
    lout_nx  = 1'b0;
    busy_nx  = 1'b0;
    err_nx   = 1'b0;
`ifdef OPERAND_CHAIN_EN
    sel_nx   = 1'b0;
`endif
    if (key_take_s) begin
      ack_nx  = 1'b1;
      tcnt_nx = 16'd0;
      if (is_clear_s) begin
        clra_nx  = 1'b1;
        clrb_nx  = 1'b1;
        op_nx    = 2'd0;
        state_nx = ST_IDLE;
      end else if (is_bad_op_s) begin
        err_nx = 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (!KeyIsOp) begin
              lata_nx  = 1'b1;
              state_nx = ST_GOT_A;
            end else begin
              err_nx = 1'b1;
            end
          end
          ST_GOT_A: begin
            if (!KeyIsOp) begin
              lata_nx = 1'b1;
            end else begin
              op_nx    = KeyCode[1:0];
              state_nx = ST_WAIT_B;
            end
          end
          ST_WAIT_B: begin
            if (!KeyIsOp) begin
              latb_nx  = 1'b1;
              ecnt_nx  = 4'd0;
              state_nx = ST_EXEC;
            end else begin
              op_nx = KeyCode[1:0];
            end
          end
          ST_SHOW: begin
            if (!KeyIsOp) begin
              clrb_nx  = 1'b1;
              lata_nx  = 1'b1;
              state_nx = ST_GOT_A;
            end else begin
`ifdef OPERAND_CHAIN_EN
              sel_nx   = 1'b1;
              lata_nx  = 1'b1;
              clrb_nx  = 1'b1;
              op_nx    = KeyCode[1:0];
              state_nx = ST_WAIT_B;
`else
              err_nx = 1'b1;
`endif
            end
          end
          default: begin
            state_nx = ST_IDLE;
          end
        endcase
      end
    end else begin
      case (state_r)
        ST_WAIT_B: begin
          if (TIMEOUT_EN && (tcnt_r == TLIM)) begin
            clra_nx  = 1'b1;
            clrb_nx  = 1'b1;
            err_nx   = 1'b1;
            tcnt_nx  = 16'd0;
            state_nx = ST_IDLE;
          end else begin
            tcnt_nx = tcnt_r + 16'd1;
          end
        end
        ST_EXEC: begin
          if (ecnt_r == ELAST) begin
            lout_nx  = 1'b1;
            ecnt_nx  = 4'd0;
            state_nx = ST_SHOW;
          end else begin
            busy_nx = 1'b1;
            ecnt_nx = ecnt_r + 4'd1;
          end
        end
        default: begin
          state_nx = state_r;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset aborts any operation.
  always_ff @(posedge MainClock or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= ST_IDLE;
      ecnt_r  <= 4'd0;
      tcnt_r  <= 16'd0;
      ack_r   <= 1'b0;
      lata_r  <= 1'b0;
      latb_r  <= 1'b0;
      clra_r  <= 1'b0;
      clrb_r  <= 1'b0;
      op_r    <= 2'd0;
      lout_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      ecnt_r  <= ecnt_nx;
      tcnt_r  <= tcnt_nx;
      ack_r   <= ack_nx;
      lata_r  <= lata_nx;
      latb_r  <= latb_nx;
      clra_r  <= clra_nx;
      clrb_r  <= clrb_nx;
      op_r    <= op_nx;
      lout_r  <= lout_nx;
      busy_r  <= busy_nx;
      err_r   <= err_nx;
    end
  end

`ifdef OPERAND_CHAIN_EN
  // Result-to-A mux select, one pulse alongside the chaining LatchA.
  always_ff @(posedge MainClock or negedge ResetN) begin
    if (!ResetN) begin
      sel_r <= 1'b0;
    end else begin
      sel_r <= sel_nx;
    end
  end
  assign SelResult = sel_r;
`else
  assign SelResult = 1'b0;
`endif

  assign KeyAck   = ack_r;
  assign LatchA   = lata_r;
  assign LatchB   = latb_r;
  assign ClearA   = clra_r;
  assign ClearB   = clrb_r;
  assign AluOp    = op_r;
  assign LatchOut = lout_r;
  assign Busy     = busy_r;
  assign Error    = err_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer. The reference model tracks the
// calculator mode and schedules time-based events (settle window, timeout)
// from cycle stamps; every cycle the full output vector is compared.
module tb_operand_sequencer;
  localparam int EXEC_CYCLES = 2;
  localparam int TIMEOUT_CYC = 255;

  localparam int M_IDLE = 0;
  localparam int M_GOTA = 1;
  localparam int M_WAITB = 2;
  localparam int M_EXEC = 3;
  localparam int M_SHOW = 4;

  logic       MainClock = 1'b0;
  logic       ResetN    = 1'b0;
  logic       KeyValid  = 1'b0;
  logic       KeyIsOp   = 1'b0;
  logic [3:0] KeyCode   = 4'h0;
  logic       KeyAck, LatchA, LatchB, ClearA, ClearB, LatchOut, SelResult, Busy, Error;
  logic [1:0] AluOp;

  operand_sequencer #(.EXEC_CYCLES(EXEC_CYCLES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .MainClock(MainClock), .ResetN(ResetN), .KeyValid(KeyValid), .KeyIsOp(KeyIsOp),
    .KeyCode(KeyCode), .KeyAck(KeyAck), .LatchA(LatchA), .LatchB(LatchB),
    .ClearA(ClearA), .ClearB(ClearB), .AluOp(AluOp), .LatchOut(LatchOut),
    .SelResult(SelResult), .Busy(Busy), .Error(Error)
  );

  always #5 MainClock = ~MainClock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model
  int         mode;
  logic [1:0] m_op;
  logic       m_last_ack;
  int         lb_cyc;
  int         key_cyc;
  logic [11:0] exp_v, obs_v;

  // observations for named checks
  int obs_lb, obs_lout, obs_abort, busy_cnt, err_cnt, sel_cnt;
  logic [1:0] op_at_lout;

  task automatic reset_model();
    mode = M_IDLE; m_op = 2'd0; m_last_ack = 1'b0; lb_cyc = -1000; key_cyc = 0;
  endtask

  // Predict outputs for cycle n from the inputs present at its opening edge.
  task automatic model_edge(input int n);
    logic ack, la, lb, ca, cb, lo, sel, busy, err;
    bit take;
    {ack, la, lb, ca, cb, lo, sel, busy, err} = 9'd0;
    take = KeyValid && !m_last_ack && (mode != M_EXEC);
    if (mode == M_EXEC) begin
      if (n > lb_cyc && n <= lb_cyc + EXEC_CYCLES) busy = 1'b1;
      if (n == lb_cyc + EXEC_CYCLES + 1) begin lo = 1'b1; mode = M_SHOW; end
    end else if (take) begin
      ack = 1'b1;
      if (KeyIsOp && KeyCode == 4'hF) begin
        ca = 1'b1; cb = 1'b1; m_op = 2'd0; mode = M_IDLE;
      end else if (KeyIsOp && KeyCode > 4'h3) begin
        err = 1'b1;
      end else if (!KeyIsOp) begin
        case (mode)
          M_IDLE, M_GOTA: begin la = 1'b1; mode = M_GOTA; end
          M_WAITB: begin lb = 1'b1; lb_cyc = n; mode = M_EXEC; end
          M_SHOW: begin la = 1'b1; cb = 1'b1; mode = M_GOTA; end
          default: ;
        endcase
      end else begin
        case (mode)
          M_IDLE: err = 1'b1;
          M_GOTA, M_WAITB: begin m_op = KeyCode[1:0]; mode = M_WAITB; end
          M_SHOW: begin
`ifdef OPERAND_CHAIN_EN
            sel = 1'b1; la = 1'b1; cb = 1'b1; m_op = KeyCode[1:0]; mode = M_WAITB;
`else
            err = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      if (mode == M_WAITB) key_cyc = n;
    end else if (mode == M_WAITB && TIMEOUT_CYC != 0 && n == key_cyc + TIMEOUT_CYC) begin
      ca = 1'b1; cb = 1'b1; err = 1'b1; mode = M_IDLE;
    end
    m_last_ack = ack;
    exp_v = {ack, la, lb, ca, cb, m_op, lo, sel, busy, err};
  endtask

  task automatic tick();
    @(posedge MainClock);
    model_edge(cyc);
    #1;
    obs_v = {KeyAck, LatchA, LatchB, ClearA, ClearB, AluOp, LatchOut, SelResult, Busy, Error};
    tests++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL cycle%0d outputs observed=%b expected=%b (ack,la,lb,ca,cb,op,lo,sel,busy,err)",
             cyc, obs_v, exp_v);
    end
    if (LatchB) obs_lb = cyc;
    if (LatchOut) begin obs_lout = cyc; op_at_lout = AluOp; end
    if (ClearA && ClearB && Error) obs_abort = cyc;
    if (Busy) busy_cnt++;
    if (Error) err_cnt++;
    if (SelResult) sel_cnt++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic op, input logic [3:0] code, output int ack_at);
    bit ok;
    ok = 1'b0;
    ack_at = -1;
    KeyValid = 1'b1; KeyIsOp = op; KeyCode = code;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (KeyAck) begin ok = 1'b1; ack_at = cyc - 1; end
    end
    KeyValid = 1'b0;
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL key_ack_wait observed=no_ack expected=ack (key op=%0b code=%h)", op, code);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    tests++;
    assert ({KeyAck, LatchA, LatchB, ClearA, ClearB, AluOp, LatchOut, SelResult, Busy, Error} === 12'd0)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=0", tag,
             {KeyAck, LatchA, LatchB, ClearA, ClearB, AluOp, LatchOut, SelResult, Busy, Error});
    end
  endtask

  initial begin
    int a, op_ack, lout_before, r;
    reset_model();
    // reset state
    #2;
    check_zero("reset_outputs");
    repeat (2) @(posedge MainClock);
    @(negedge MainClock);
    ResetN = 1'b1;
    idle(2);

    // digit 3, op add, digit 5: settle window and Busy length
    busy_cnt = 0;
    press(1'b0, 4'h3, a);
    press(1'b1, 4'h0, a);
    press(1'b0, 4'h5, a);
    idle(6);
    check_int("lout_after_latchb", obs_lout - obs_lb, EXEC_CYCLES + 1);
    check_int("busy_cycles", busy_cnt, EXEC_CYCLES);

    // digit 2, op sub, op or, digit 1: last op wins, no errors
    err_cnt = 0;
    press(1'b0, 4'h2, a);
    press(1'b1, 4'h1, a);
    press(1'b1, 4'h3, a);
    press(1'b0, 4'h1, a);
    idle(6);
    check_int("aluop_at_lout", int'(op_at_lout), 3);
    check_int("no_error_run", err_cnt, 0);

    // clear, then op key in IDLE gives exactly one error
    press(1'b1, 4'hF, a);
    err_cnt = 0;
    press(1'b1, 4'h0, a);
    idle(2);
    check_int("idle_op_error", err_cnt, 1);

    // WAIT_B timeout
    press(1'b0, 4'h4, a);
    obs_abort = -1;
    press(1'b1, 4'h0, op_ack);
    idle(TIMEOUT_CYC + 4);
    check_int("timeout_delay", obs_abort - op_ack, TIMEOUT_CYC);

    // key held during EXEC is only acked once SHOW is reached
    press(1'b0, 4'h1, a);
    press(1'b1, 4'h2, a);
    press(1'b0, 4'h6, a);
    press(1'b0, 4'h9, a);
    check_int("held_key_ack", a, obs_lout + 1);

    // op key in SHOW: chaining or error
    press(1'b1, 4'h2, a);
    press(1'b0, 4'h1, a);
    idle(6);
    err_cnt = 0; sel_cnt = 0;
    press(1'b1, 4'h2, a);
    press(1'b0, 4'h7, a);
    idle(6);
`ifdef OPERAND_CHAIN_EN
    check_int("chain_sel", sel_cnt, 1);
    check_int("chain_aluop", int'(op_at_lout), 2);
`else
    check_int("nochain_error", err_cnt, 1);
    check_int("nochain_sel", sel_cnt, 0);
`endif

    // reset in the middle of EXEC
    press(1'b1, 4'hF, a);
    press(1'b0, 4'h3, a);
    press(1'b1, 4'h1, a);
    press(1'b0, 4'h2, a);
    tick();
    lout_before = obs_lout;
    #2;
    ResetN = 1'b0;
    #1;
    check_zero("reset_in_exec");
    repeat (2) @(posedge MainClock);
    @(negedge MainClock);
    ResetN = 1'b1;
    reset_model();
    idle(6);
    check_int("no_lout_after_reset", obs_lout, lout_before);

    // randomized key stream against the model
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 19);
      if (r < 10) press(1'b0, 4'($urandom_range(0, 9)), a);
      else if (r < 16) press(1'b1, 4'($urandom_range(0, 3)), a);
      else if (r < 17) press(1'b1, 4'hF, a);
      else press(1'b1, 4'($urandom_range(4, 14)), a);
      idle($urandom_range(0, 4));
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
